// File: rtl/button_pulse_debounce.sv
// Debounces a raw push-button into a clean level plus press/release strobes.
// Optional auto-repeat strobe while held is built when BUTTON_AUTOREPEAT_EN is defined.
module button_pulse_debounce #(
    parameter int DEBOUNCE_CYCLES = 270_000,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int REPEAT_DELAY    = 13_500_000,
    parameter int REPEAT_PERIOD   = 2_700_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic REL_LEVEL = ACTIVE_LOW;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          pressed_q, pressed_d;
    logic          press_pulse_q, press_pulse_d;
    logic          release_pulse_q, release_pulse_d;
    logic          s;

    // Polarity-corrected synchronized sample: 1 means the button is pressed.
    assign s = sync2_q ^ ACTIVE_LOW;

    always_comb begin
        sync1_d = btn_in;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RELEASED: begin
                if (s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = HELD;
                        cnt_d   = '0;
                    end else begin
                        state_d = PRESS_WAIT;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (!s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = RELEASED;
                        cnt_d   = '0;
                    end else begin
                        state_d = RELEASE_WAIT;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
        pressed_d       = (state_d == HELD) || (state_d == RELEASE_WAIT);
        press_pulse_d   = pressed_d && !pressed_q;
        release_pulse_d = !pressed_d && pressed_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q         <= REL_LEVEL;
            sync2_q         <= REL_LEVEL;
            state_q         <= RELEASED;
            cnt_q           <= '0;
            pressed_q       <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
        end else begin
            sync1_q         <= sync1_d;
            sync2_q         <= sync2_d;
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            pressed_q       <= pressed_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
        end
    end

    assign pressed       = pressed_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] TMR_ONE = TW'(1);

    logic [TW-1:0] rpt_tmr_q, rpt_tmr_d;
    logic          repeat_pulse_q, repeat_pulse_d;

    // Timer restarts only on a fresh press; a release glitch that bounces back keeps counting.
    always_comb begin
        rpt_tmr_d      = rpt_tmr_q;
        repeat_pulse_d = 1'b0;
        if (press_pulse_d) begin
            rpt_tmr_d = TW'(REPEAT_DELAY);
        end else if (!pressed_d) begin
            rpt_tmr_d = '0;
        end else if (rpt_tmr_q == TMR_ONE) begin
            repeat_pulse_d = 1'b1;
            rpt_tmr_d      = TW'(REPEAT_PERIOD);
        end else if (rpt_tmr_q != '0) begin
            rpt_tmr_d = rpt_tmr_q - TMR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_tmr_q      <= '0;
            repeat_pulse_q <= 1'b0;
        end else begin
            rpt_tmr_q      <= rpt_tmr_d;
            repeat_pulse_q <= repeat_pulse_d;
        end
    end

    assign repeat_pulse = repeat_pulse_q;
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_pulse_debounce.sv
// Self-checking bench for button_pulse_debounce: per-cycle scoreboard against a
// net-rule debounce model, plus directed latency and strobe-count checks.
module tb_button_pulse_debounce;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic clk = 1'b0;
    logic rst;
    logic btn_in;
    logic pressed, press_pulse, release_pulse, repeat_pulse;

    button_pulse_debounce #(
        .DEBOUNCE_CYCLES(D),
        .ACTIVE_LOW(1'b1),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_in(btn_in),
        .pressed(pressed),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .repeat_pulse(repeat_pulse)
    );

    always #5 clk = ~clk;

    int    n_pass  = 0;
    int    n_total = 0;
    string phase   = "reset";

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Model: s is the button sampled two edges earlier; the accepted level flips
    // after D consecutive samples that differ from it.
    logic       b1_m = 1'b1, b2_m = 1'b1, acc_m = 1'b0;
    logic       s_m, pp_m, rp_m, rep_m;
    int         run_m = 0, tmr_m = 0, cyc = 0;
    logic [3:0] exp_q[$];

    always @(posedge clk) begin
        cyc++;
        pp_m = 1'b0; rp_m = 1'b0; rep_m = 1'b0;
        if (rst) begin
            b1_m = 1'b1; b2_m = 1'b1; acc_m = 1'b0; run_m = 0; tmr_m = 0;
        end else begin
            s_m  = ~b2_m;
            b2_m = b1_m;
            b1_m = btn_in;
            if (s_m != acc_m) begin
                run_m++;
                if (run_m == D) begin
                    acc_m = s_m; run_m = 0; pp_m = s_m; rp_m = ~s_m;
                end
            end else begin
                run_m = 0;
            end
`ifdef BUTTON_AUTOREPEAT_EN
            if (pp_m) tmr_m = RD;
            else if (!acc_m) tmr_m = 0;
            else begin
                tmr_m--;
                if (tmr_m == 0) begin rep_m = 1'b1; tmr_m = RP; end
            end
`endif
        end
        exp_q.push_back({acc_m, pp_m, rp_m, rep_m});
    end

    int n_press = 0, n_rel = 0, n_rep = 0;
    int last_press_cyc = 0, last_rel_cyc = 0;
    logic [3:0] exp_v;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            check_eq({"cyc_", phase}, {28'd0, pressed, press_pulse, release_pulse, repeat_pulse}, {28'd0, exp_v});
        end
        if (press_pulse)   begin n_press++; last_press_cyc = cyc; end
        if (release_pulse) begin n_rel++;   last_rel_cyc   = cyc; end
        if (repeat_pulse)  n_rep++;
    end

    task automatic tick(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    // Index of the edge carrying the strobe, counting the first edge after the call as 0.
    task automatic wait_evt(input bit want_rel, output int idx);
        idx = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (want_rel ? release_pulse : press_pulse) begin idx = i; break; end
        end
    endtask

    int idx;

    initial begin
        rst = 1'b1; btn_in = 1'b0;
        tick(8);
        check_eq("rst_pressed", {31'd0, pressed}, 32'd0);
        rst = 1'b0; phase = "post_rst";
        wait_evt(1'b0, idx);
        check_eq("rst_to_press", idx, 32'd5);
        tick(3);
        check_eq("held_level", {31'd0, pressed}, 32'd1);

        phase = "release"; btn_in = 1'b1;
        wait_evt(1'b1, idx);
        check_eq("release_lat", idx, 32'd5);
        tick(3);

        phase = "hold"; btn_in = 1'b0;
        wait_evt(1'b0, idx);
        check_eq("press_lat", idx, 32'd5);
        n_rep = 0;
        tick(30);
`ifdef BUTTON_AUTOREPEAT_EN
        check_eq("repeat_count", n_rep, 32'd7);
`else
        check_eq("repeat_count", n_rep, 32'd0);
`endif
        btn_in = 1'b1;
        wait_evt(1'b1, idx);
        check_eq("hold_release_lat", idx, 32'd5);
        n_rep = 0;
        tick(20);
        check_eq("no_repeat_after_rel", n_rep, 32'd0);

        phase = "bounce"; n_press = 0; n_rel = 0;
        for (int i = 0; i < 15; i++) begin
            btn_in = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(2);
        end
        btn_in = 1'b1;
        tick(10);
        check_eq("bounce_press", n_press, 32'd0);
        check_eq("bounce_release", n_rel, 32'd0);

        phase = "glitch3"; btn_in = 1'b0;
        tick(3);
        btn_in = 1'b1;
        tick(12);
        check_eq("glitch3_press", n_press, 32'd0);

        phase = "glitch4"; btn_in = 1'b0;
        tick(4);
        btn_in = 1'b1;
        tick(15);
        check_eq("glitch4_press", n_press, 32'd1);
        check_eq("glitch4_release", n_rel, 32'd1);
        check_eq("glitch4_gap", last_rel_cyc - last_press_cyc, 32'd4);

        phase = "rst_held"; btn_in = 1'b0;
        wait_evt(1'b0, idx);
        check_eq("press_before_rst", idx, 32'd5);
        tick(2);
        n_rel = 0;
        rst = 1'b1;
        tick(1);
        check_eq("rst_drops_pressed", {31'd0, pressed}, 32'd0);
        rst = 1'b0;
        wait_evt(1'b0, idx);
        check_eq("rst_held_repress", idx, 32'd5);
        check_eq("rst_no_release", n_rel, 32'd0);
        tick(4);
        btn_in = 1'b1;
        tick(12);

        // Random press/release lengths checked by the per-cycle scoreboard.
        phase = "random";
        for (int i = 0; i < 20; i++) begin
            btn_in = ~btn_in;
            tick($urandom_range(1, 9));
        end
        btn_in = 1'b1;
        tick(15);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
